hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Parametrised successor to the fixed load-use hazard detector and branch flush detector in the 5-stage MIPS pipeline.
- Centralises all pipeline-control decisions:
  - load-use stalls;
  - stalls for branch operands compared in ID;
  - flush of IF/ID on a taken branch or jump;
  - whole-pipeline freeze while a multi-cycle data memory access is pending.
- Keeps saturating performance counters for stall, flush and memory-wait cycles.
- Sits beside the forwarding units and drives the PC and pipeline-register enables.

Parameters:
- REG_ADDR_W, 5, width of register specifiers.
- CNT_W, 16, width of each performance counter.
- BRANCH_IN_ID, 1, 1 = branches resolve in ID (dependency stalls apply); 0 = ID-branch dependency rules disabled.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- id_rs, id_rt  in  REG_ADDR_W  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1  instruction in ID reads rs / rt.
- id_branch  in  1  ID holds beq/bne.
- id_branch_taken  in  1  ID comparator result (valid only when operands are ready).
- id_jump  in  1  ID holds j.
- ex_regwrite, ex_memread  in  1  controls of the instruction in EX.
- ex_dest  in  REG_ADDR_W  destination register of the instruction in EX.
- mem_regwrite, mem_memread  in  1  controls of the instruction in MEM.
- mem_dest  in  REG_ADDR_W  destination register of the instruction in MEM.
- dmem_req  in  1  MEM stage is issuing a load/store this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_bubble  out  1  zero ID/EX control bits.
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- stall_cnt, flush_cnt, memwait_cnt  out  CNT_W  performance counters.

Behaviour:
- State machine: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT: dmem_req=1 and dmem_ready=0.
  - MEM_WAIT -> RUN: dmem_ready=1.
  - Reset forces RUN and clears all counters to 0 asynchronously.
- Register 0 never creates a hazard: any match on dest==0 is ignored.
- "uses X" below means id_uses_rs with id_rs==X, or id_uses_rt with id_rt==X.
- Data-hazard term H (combinational):
  - H1, load-use: ex_memread and uses ex_dest.
  - H2, branch after ALU op (BRANCH_IN_ID=1): id_branch, ex_regwrite, not ex_memread, uses ex_dest.
  - H3, branch after load in MEM (BRANCH_IN_ID=1): id_branch, mem_memread, uses mem_dest.
  - Load in EX feeding a branch: H1 now, then H3 next cycle, giving 2 bubbles in total.
  - H = H1 | H2 | H3.
- Freeze term F = (state==MEM_WAIT & ~dmem_ready) | (state==RUN & dmem_req & ~dmem_ready).
- Outputs are combinational, evaluated in priority order:
  1. F=1: pipe_freeze=1, pc_write=0, if_id_write=0, id_ex_bubble=0, if_id_flush=0.
  2. H=1: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0, pipe_freeze=0.
  3. (id_branch & id_branch_taken) | id_jump: if_id_flush=1, pc_write=1, if_id_write=1.
  4. Otherwise: pc_write=1, if_id_write=1, all others 0.
- Branch outcome is ignored while H or F is asserted; flush occurs only on the cycle the branch actually resolves.
- While reset is high: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0, pipe_freeze=0, state=RUN.
- Counters, registered on the rising edge, each saturating at all-ones (no wrap):
  - stall_cnt increments on cycles where H=1 and F=0.
  - flush_cnt increments on cycles where if_id_flush=1.
  - memwait_cnt increments on cycles where F=1.
- Simultaneous dmem_req and dmem_ready in RUN: a single-cycle access, no freeze, state remains RUN.
- Reset asserted mid-MEM_WAIT: returns to RUN immediately and outputs drop to the reset values.

Test Plan:
- lw $t0 in EX (ex_memread=1, ex_dest=8), ID add with rs=8 -> one cycle of pc_write=0, id_ex_bubble=1; stall_cnt 0->1.
- ALU op with ex_dest=9, ID beq with rt=9 -> 1 bubble. Load with ex_dest=9 followed by beq reading 9 -> 2 consecutive bubbles; stall_cnt=2.
- ID beq, id_branch_taken=1, no hazard -> if_id_flush=1 for 1 cycle; flush_cnt=1. id_jump=1 gives the same response. Taken beq under H2 -> no flush until the stall clears.
- dmem_req=1, dmem_ready held low 3 cycles then high -> pipe_freeze=1 for 3 cycles, memwait_cnt=3, state back to RUN. A concurrent load-use hazard in ID is deferred until the freeze ends.
- ex_dest=0 with ex_memread=1 and ID reading $0 -> no stall.
- Preload or drive stall_cnt to 0xFFFF, then further stalls -> stall_cnt stays 0xFFFF.
- Assert reset during MEM_WAIT -> all counters 0, pc_write=0 while reset is high, state RUN after release.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Central pipeline-control block for the 5-stage MIPS pipeline.
// It decides stalls, flushes and memory-wait freezes, and keeps
// saturating performance counters.
//
// Ports:
//   clock, reset       rising-edge clock, async active-high reset
//   id_*               source operands and branch/jump of ID
//   ex_*, mem_*        write/load controls and destinations of EX, MEM
//   dmem_req/ready     data-memory access handshake from MEM
//   pc_write           PC enable
//   if_id_write        IF/ID enable
//   if_id_flush        clear IF/ID to a NOP
//   id_ex_bubble       zero the ID/EX control bits
//   pipe_freeze        hold ID/EX, EX/MEM and MEM/WB
//   *_cnt              stall / flush / memory-wait cycle counters
module hazard_stall_controller #(
    parameter int REG_ADDR_W   = 5,
    parameter int CNT_W        = 16,
    parameter int BRANCH_IN_ID = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_branch,
    input  logic                  id_branch_taken,
    input  logic                  id_jump,
    input  logic                  ex_regwrite,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  mem_regwrite,
    input  logic                  mem_memread,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  pipe_freeze,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      memwait_cnt
);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    localparam logic             BID = (BRANCH_IN_ID != 0);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    state_t state;
    state_t state_nxt;

    logic uses_ex;
    logic uses_mem;
    logic h1;
    logic h2;
    logic h3;
    logic hz;
    logic frz;
    logic redirect;

    // A write to $0 is discarded, so it can never be a producer.
    assign uses_ex = (ex_dest != '0) &&
                     ((id_uses_rs && id_rs == ex_dest) ||
                      (id_uses_rt && id_rt == ex_dest));
    assign uses_mem = (mem_dest != '0) &&
                      ((id_uses_rs && id_rs == mem_dest) ||
                       (id_uses_rt && id_rt == mem_dest));

    assign h1 = ex_memread && uses_ex;
    assign h2 = BID && id_branch && ex_regwrite &&
                !ex_memread && uses_ex;
    assign h3 = BID && id_branch && mem_memread && uses_mem;
    assign hz = h1 || h2 || h3;

    // mem_regwrite only matters to forwarding; loads in MEM are
    // caught through mem_memread.
    logic unused_mem_rw;
    assign unused_mem_rw = mem_regwrite;

    assign frz = !dmem_ready &&
                 ((state == MEM_WAIT) || dmem_req);

    assign redirect = (id_branch && id_branch_taken) || id_jump;

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:      if (dmem_req && !dmem_ready) state_nxt = MEM_WAIT;
            MEM_WAIT: if (dmem_ready)              state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        if (!reset) begin
            if (frz) begin
                pipe_freeze = 1'b1;
            end else if (hz) begin
                id_ex_bubble = 1'b1;
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                if_id_flush = redirect;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            memwait_cnt <= '0;
        end else begin
            if (hz && !frz && stall_cnt != MAX)
                stall_cnt <= stall_cnt + ONE;
            if (if_id_flush && flush_cnt != MAX)
                flush_cnt <= flush_cnt + ONE;
            if (frz && memwait_cnt != MAX)
                memwait_cnt <= memwait_cnt + ONE;
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: a driver pushes
// expected responses, a monitor pops and compares them each cycle.
module tb_hazard_stall_controller;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_dest = '0, mem_dest = '0;
    logic id_uses_rs = 0, id_uses_rt = 0, id_branch = 0;
    logic id_branch_taken = 0, id_jump = 0;
    logic ex_regwrite = 0, ex_memread = 0;
    logic mem_regwrite = 0, mem_memread = 0;
    logic dmem_req = 0, dmem_ready = 0;

    logic a_pcw, a_ifw, a_fl, a_bub, a_frz;
    logic b_pcw, b_ifw, b_fl, b_bub, b_frz;
    logic [15:0] a_sc, a_fc, a_mc, b_sc, b_fc, b_mc;

    always #5 clock = ~clock;

    hazard_stall_controller #(.REG_ADDR_W(5), .CNT_W(16), .BRANCH_IN_ID(1)) dut_a (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_branch(id_branch), .id_branch_taken(id_branch_taken),
        .id_jump(id_jump),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_dest(ex_dest),
        .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .mem_dest(mem_dest),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(a_pcw), .if_id_write(a_ifw), .if_id_flush(a_fl),
        .id_ex_bubble(a_bub), .pipe_freeze(a_frz),
        .stall_cnt(a_sc), .flush_cnt(a_fc), .memwait_cnt(a_mc)
    );

    hazard_stall_controller #(.REG_ADDR_W(5), .CNT_W(16), .BRANCH_IN_ID(0)) dut_b (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_branch(id_branch), .id_branch_taken(id_branch_taken),
        .id_jump(id_jump),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_dest(ex_dest),
        .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .mem_dest(mem_dest),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(b_pcw), .if_id_write(b_ifw), .if_id_flush(b_fl),
        .id_ex_bubble(b_bub), .pipe_freeze(b_frz),
        .stall_cnt(b_sc), .flush_cnt(b_fc), .memwait_cnt(b_mc)
    );

    typedef struct packed {
        logic       rst;
        logic [4:0] rs, rt;
        logic       urs, urt, br, tk, jp, exrw, exmr;
        logic [4:0] exd;
        logic       mrw, mmr;
        logic [4:0] md;
        logic       req, rdy;
    } stim_t;

    typedef struct packed {
        logic        pcw, ifw, fl, bub, frz;
        logic [15:0] sc, fc, mc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int total = 0;
    int bad = 0;
    bit done = 0;

    // Reference model: an outstanding access flag and three counters
    // per instance (index 0 = branches in ID, 1 = ID rules off).
    bit waiting = 0;
    logic [15:0] m_sc[2], m_fc[2], m_mc[2];

    function automatic bit reads(stim_t s, logic [4:0] r);
        return r != 0 && ((s.urs && s.rs == r) || (s.urt && s.rt == r));
    endfunction

    function automatic bit hazard(stim_t s, bit bid);
        bit load_use, br_dep;
        load_use = s.exmr && reads(s, s.exd);
        br_dep = s.br && ((s.exrw && !s.exmr && reads(s, s.exd)) ||
                          (s.mmr && reads(s, s.md)));
        return load_use || (bid && br_dep);
    endfunction

    function automatic logic [15:0] sat(logic [15:0] v, bit inc);
        return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e[2];
        bit fz, h;
        @(negedge clock);
        reset = s.rst;
        id_rs = s.rs; id_rt = s.rt;
        id_uses_rs = s.urs; id_uses_rt = s.urt;
        id_branch = s.br; id_branch_taken = s.tk; id_jump = s.jp;
        ex_regwrite = s.exrw; ex_memread = s.exmr; ex_dest = s.exd;
        mem_regwrite = s.mrw; mem_memread = s.mmr; mem_dest = s.md;
        dmem_req = s.req; dmem_ready = s.rdy;
        fz = !s.rst && !s.rdy && (waiting || s.req);
        for (int b = 0; b < 2; b++) begin
            h = hazard(s, b == 0);
            if (s.rst) begin
                m_sc[b] = 0; m_fc[b] = 0; m_mc[b] = 0;
            end
            e[b] = '0;
            e[b].sc = m_sc[b]; e[b].fc = m_fc[b]; e[b].mc = m_mc[b];
            if (s.rst) begin
            end else if (fz) begin
                e[b].frz = 1;
            end else if (h) begin
                e[b].bub = 1;
            end else begin
                e[b].pcw = 1; e[b].ifw = 1;
                e[b].fl = (s.br && s.tk) || s.jp;
            end
            if (!s.rst) begin
                m_sc[b] = sat(m_sc[b], h && !fz);
                m_fc[b] = sat(m_fc[b], e[b].fl);
                m_mc[b] = sat(m_mc[b], fz);
            end
        end
        qa.push_back(e[0]);
        qb.push_back(e[1]);
        // An access stays outstanding exactly while the pipe is frozen.
        waiting = fz;
    endtask

    task automatic check(string n, logic [15:0] got, logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", n, got, exp, $time);
        end
    endtask

    initial begin : driver
        stim_t s;
        m_sc = '{0, 0}; m_fc = '{0, 0}; m_mc = '{0, 0};
        s = '0; s.rst = 1;
        repeat (3) drive(s);
        s = '0; drive(s);
        // load-use
        s = '0; s.exmr = 1; s.exrw = 1; s.exd = 8; s.rs = 8; s.urs = 1;
        drive(s);
        s = '0; drive(s);
        // ALU op feeding a taken beq: stall, then flush
        s = '0; s.exrw = 1; s.exd = 9; s.br = 1; s.tk = 1;
        s.rt = 9; s.urt = 1; drive(s);
        s.exrw = 0; s.exd = 0; drive(s);
        // load feeding beq: two bubbles
        s = '0; s.exmr = 1; s.exrw = 1; s.exd = 9; s.br = 1;
        s.rt = 9; s.urt = 1; drive(s);
        s.exmr = 0; s.exrw = 0; s.exd = 0;
        s.mmr = 1; s.mrw = 1; s.md = 9; drive(s);
        s.mmr = 0; s.mrw = 0; s.md = 0; drive(s);
        // jump
        s = '0; s.jp = 1; drive(s);
        // 3-cycle memory wait with a deferred load-use
        s = '0; s.req = 1; s.exmr = 1; s.exd = 8; s.rs = 8; s.urs = 1;
        drive(s);
        s.req = 0; drive(s); drive(s);
        s.rdy = 1; drive(s);
        s = '0; drive(s);
        // single-cycle access
        s = '0; s.req = 1; s.rdy = 1; drive(s);
        // $0 never hazards
        s = '0; s.exmr = 1; s.exd = 0; s.urs = 1; s.rs = 0; drive(s);
        // reset in the middle of a wait
        s = '0; s.req = 1; drive(s);
        s.req = 0; drive(s);
        s.rst = 1; drive(s); drive(s);
        s = '0; drive(s);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            s.rst  = ($urandom_range(0, 199) == 0);
            s.rs   = 5'($urandom_range(0, 3));
            s.rt   = 5'($urandom_range(0, 3));
            s.exd  = 5'($urandom_range(0, 3));
            s.md   = 5'($urandom_range(0, 3));
            s.urs  = 1'($urandom); s.urt = 1'($urandom);
            s.br   = 1'($urandom); s.tk  = 1'($urandom);
            s.jp   = ($urandom_range(0, 7) == 0);
            s.exrw = 1'($urandom); s.exmr = 1'($urandom);
            s.mrw  = 1'($urandom); s.mmr  = 1'($urandom);
            s.req  = ($urandom_range(0, 3) == 0);
            s.rdy  = 1'($urandom);
            drive(s);
        end
        // saturate stall counters
        s = '0; s.rst = 1; drive(s);
        s = '0; s.exmr = 1; s.exd = 8; s.rs = 8; s.urs = 1;
        repeat (65540) drive(s);
        s = '0; drive(s);
        s.rst = 1; drive(s);
        s = '0; drive(s);
        done = 1;
    end

    initial begin : monitor
        exp_t e;
        while (1) begin
            @(negedge clock);
            #2;
            if (qa.size() == 0) begin
                if (done) break;
                continue;
            end
            e = qa.pop_front();
            check("a.pc_write", 16'(a_pcw), 16'(e.pcw));
            check("a.if_id_write", 16'(a_ifw), 16'(e.ifw));
            check("a.if_id_flush", 16'(a_fl), 16'(e.fl));
            check("a.id_ex_bubble", 16'(a_bub), 16'(e.bub));
            check("a.pipe_freeze", 16'(a_frz), 16'(e.frz));
            check("a.stall_cnt", a_sc, e.sc);
            check("a.flush_cnt", a_fc, e.fc);
            check("a.memwait_cnt", a_mc, e.mc);
            e = qb.pop_front();
            check("b.pc_write", 16'(b_pcw), 16'(e.pcw));
            check("b.if_id_write", 16'(b_ifw), 16'(e.ifw));
            check("b.if_id_flush", 16'(b_fl), 16'(e.fl));
            check("b.id_ex_bubble", 16'(b_bub), 16'(e.bub));
            check("b.pipe_freeze", 16'(b_frz), 16'(e.frz));
            check("b.stall_cnt", b_sc, e.sc);
            check("b.flush_cnt", b_fc, e.fc);
            check("b.memwait_cnt", b_mc, e.mc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
